serial_addsub_digit: RTL

Parametrised digit-serial adder/subtractor: two operands of `N_DIGITS` digits, each `DIGIT_W` bits wide, are streamed in LSB-digit first, and one result digit is produced per accepted input digit. The sum output is Mealy: it is combinational from the registered carry state and the current input digits. It supersedes the single-bit, free-running serial adder with the following additions:

- runtime add/subtract mode
- word framing with a start/done handshake
- input flow control
- carry-out and signed-overflow flags

It sits between operand shift registers and a result deserialiser in the datapath.

---
 rtl/serial_addsub_digit_pkg.sv | 14 +
 rtl/serial_addsub_digit_if.sv | 26 ++
 rtl/serial_addsub_digit_adder.sv | 34 +++
 rtl/serial_addsub_digit.sv | 125 ++++++++++++
 4 files changed

// File: rtl/serial_addsub_digit_pkg.sv
// Shared types and helpers for the digit-serial adder/subtractor.
package serial_addsub_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Digit counter width; a single-digit word still needs one counter bit.
  function automatic int cnt_width(input int n_digits);
    return (n_digits <= 1) ? 1 : $clog2(n_digits);
  endfunction

endpackage

// File: rtl/serial_addsub_digit_if.sv
// Digit stream and handshake bundle between the operand feeder and the adder.
interface serial_addsub_digit_if #(
  parameter int DIGIT_W = 1
);
  logic               start;
  logic               sub;
  logic               in_valid;
  logic [DIGIT_W-1:0] a_dig;
  logic [DIGIT_W-1:0] b_dig;
  logic [DIGIT_W-1:0] sum_dig;
  logic               sum_valid;
  logic               busy;
  logic               done;
  logic               cout;
  logic               ovf;

  modport master (
    output start, sub, in_valid, a_dig, b_dig,
    input  sum_dig, sum_valid, busy, done, cout, ovf
  );

  modport slave (
    input  start, sub, in_valid, a_dig, b_dig,
    output sum_dig, sum_valid, busy, done, cout, ovf
  );
endinterface

// File: rtl/serial_addsub_digit_adder.sv
// Combinational DIGIT_W-bit ripple adder; also exposes the carry into the MSB
// so the top level can form signed overflow on the final digit.
module digit_adder #(
  parameter int DIGIT_W = 1
) (
  input  logic [DIGIT_W-1:0] a,
  input  logic [DIGIT_W-1:0] b,
  input  logic               cin,
  output logic [DIGIT_W-1:0] sum,
  output logic               cout,
  output logic               c_msb
);

  logic [DIGIT_W-1:0] w_sum;
  logic               w_c;
  logic               w_cmsb;

  // Bit-by-bit ripple; the running carry is captured before the MSB stage.
  always_comb begin
    w_sum  = '0;
    w_c    = cin;
    w_cmsb = 1'b0;
    for (int i = 0; i < DIGIT_W; i++) begin
      if (i == DIGIT_W - 1) w_cmsb = w_c;
      w_sum[i] = a[i] ^ b[i] ^ w_c;
      w_c      = (a[i] & b[i]) | (w_c & (a[i] ^ b[i]));
    end
  end

  assign sum   = w_sum;
  assign cout  = w_c;
  assign c_msb = w_cmsb;

endmodule

// File: rtl/serial_addsub_digit.sv
// Digit-serial adder/subtractor: operands arrive LSB digit first, one result
// digit leaves per accepted input digit (Mealy), with word framing and flags.
module serial_addsub_digit
  import serial_addsub_pkg::*;
#(
  parameter int DIGIT_W  = 1,
  parameter int N_DIGITS = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  serial_addsub_digit_if.slave bus
);

  localparam int                 CNT_W = cnt_width(N_DIGITS);
  localparam logic [CNT_W-1:0]   LAST  = CNT_W'(N_DIGITS - 1);

  state_t             r_state;
  logic               r_carry;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_sub;
  logic               r_done;
  logic               r_cout;
  logic               r_ovf;

  state_t             w_state_nx;
  logic               w_carry_nx;
  logic [CNT_W-1:0]   w_cnt_nx;
  logic               w_sub_nx;
  logic               w_done_nx;
  logic               w_cout_nx;
  logic               w_ovf_nx;

  logic               w_run;
  logic               w_acc;
  logic               w_last;
  logic [DIGIT_W-1:0] w_b_eff;
  logic [DIGIT_W-1:0] w_sum;
  logic               w_c_out;
  logic               w_c_msb;

  assign w_run   = (r_state == RUN);
  assign w_acc   = w_run & bus.in_valid;
  assign w_last  = w_acc & (r_cnt == LAST);
  // Subtraction is A + ~B + 1; the +1 comes from the carry seeded at start.
  assign w_b_eff = bus.b_dig ^ {DIGIT_W{r_sub}};

  digit_adder #(
    .DIGIT_W (DIGIT_W)
  ) u_adder (
    .a     (bus.a_dig),
    .b     (w_b_eff),
    .cin   (r_carry),
    .sum   (w_sum),
    .cout  (w_c_out),
    .c_msb (w_c_msb)
  );

  // Next-state and next-register logic for the IDLE/RUN word sequencer.
  always_comb begin
    w_state_nx = r_state;
    w_carry_nx = r_carry;
    w_cnt_nx   = r_cnt;
    w_sub_nx   = r_sub;
    w_done_nx  = 1'b0;
    w_cout_nx  = r_cout;
    w_ovf_nx   = r_ovf;
    case (r_state)
      IDLE: begin
        if (bus.start) begin
          w_sub_nx   = bus.sub;
          w_carry_nx = bus.sub;
          w_cnt_nx   = '0;
          w_cout_nx  = 1'b0;
          w_ovf_nx   = 1'b0;
          w_state_nx = RUN;
        end
      end
      RUN: begin
        if (bus.in_valid) begin
          if (w_last) begin
            w_cout_nx  = w_c_out;
            w_ovf_nx   = w_c_msb ^ w_c_out;
            w_done_nx  = 1'b1;
            w_carry_nx = 1'b0;
            w_cnt_nx   = '0;
            w_state_nx = IDLE;
          end else begin
            w_carry_nx = w_c_out;
            w_cnt_nx   = r_cnt + CNT_W'(1);
          end
        end
      end
      default: w_state_nx = IDLE;
    endcase
  end

  // State, carry, counter and flag registers; reset discards any partial word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_carry <= 1'b0;
      r_cnt   <= '0;
      r_sub   <= 1'b0;
      r_done  <= 1'b0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_carry <= w_carry_nx;
      r_cnt   <= w_cnt_nx;
      r_sub   <= w_sub_nx;
      r_done  <= w_done_nx;
      r_cout  <= w_cout_nx;
      r_ovf   <= w_ovf_nx;
    end
  end

  assign bus.sum_dig   = w_acc ? w_sum : '0;
  assign bus.sum_valid = w_acc;
  assign bus.busy      = w_run;
  assign bus.done      = r_done;
  assign bus.cout      = r_cout;
  assign bus.ovf       = r_ovf;

endmodule
